// File: rtl/pc_btb.sv
// -----------------------------------------------------------------------------
// pc_btb
//
// Fetch-address generator for the IF stage. It holds the program counter and
// advances it by 4 each cycle. A small direct-mapped branch target buffer
// (BTB) with 2-bit saturating counters steers the PC. Execute-stage redirects
// and hazard-unit stalls can override the next PC. Branch-resolution updates
// train the BTB.
//
// Parameters
//   XLEN          address width (>= log2(BTB_ENTRIES)+3)
//   RESET_VECTOR  addrOut value after reset (bits [1:0] zero)
//   BTB_ENTRIES   BTB depth, power of 2, >= 2
//
// Ports
//   clk           clock, all state updates on the rising edge
//   resetIn       synchronous active-high reset
//   locker        1 = advance, 0 = hold the PC (X/Z behaves as advance)
//   redirect      EX-stage redirect request
//   redirectAddr  redirect target (bits [1:0] ignored)
//   updValid      train the BTB this cycle
//   updPc         PC of the resolved branch
//   updTarget     resolved taken target (bits [1:0] ignored)
//   updTaken      resolved branch was taken
//   addrOut       registered fetch PC
//   predTaken     combinational taken prediction for addrOut
//   resetOut      resetIn delayed by one cycle
// -----------------------------------------------------------------------------
module pc_btb #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
  parameter int               BTB_ENTRIES  = 8
) (
  input  logic            clk,
  input  logic            resetIn,
  input  logic            locker,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectAddr,
  input  logic            updValid,
  input  logic [XLEN-1:0] updPc,
  input  logic [XLEN-1:0] updTarget,
  input  logic            updTaken,
  output logic [XLEN-1:0] addrOut,
  output logic            predTaken,
  output logic            resetOut
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam int TGTW = XLEN - 2;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  // Even parity over the non-reset payload of an entry. A corrupted tag or
  // target then reads as a miss instead of a bogus prediction.
  function automatic logic entry_parity(input logic [TAGW-1:0] tag,
                                        input logic [TGTW-1:0] tgt);
    return ^{tag, tgt};
  endfunction

  // Saturating increment of a 2-bit counter.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'd3) begin
      r = 2'd3;
    end else begin
      r = c + 2'd1;
    end
    return r;
  endfunction

  // Saturating decrement of a 2-bit counter.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'd0) begin
      r = 2'd0;
    end else begin
      r = c - 2'd1;
    end
    return r;
  endfunction

  // Architectural state
  logic [XLEN-1:0]        addr_r;
  logic                   reset_dly_r;
  logic [BTB_ENTRIES-1:0] valid_r;
  logic [1:0]             ctr_r [BTB_ENTRIES];
  logic [TAGW-1:0]        tag_r [BTB_ENTRIES];
  logic [TGTW-1:0]        tgt_r [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] par_r;

  // Lookup side
  logic [IDXW-1:0]        lk_idx_s;
  logic [TAGW-1:0]        lk_tag_s;
  logic                   lk_hit_s;
  logic                   pred_s;

  // Update side
  logic [IDXW-1:0]        upd_idx_s;
  logic [TAGW-1:0]        upd_tag_s;
  logic                   upd_hit_s;
  logic                   entry_we_s;
  logic                   ctr_we_s;
  logic [1:0]             ctr_nxt_s;

  logic [XLEN-1:0]        pc_nxt_s;

  // The low address bits of these inputs are don't-care by definition.
  logic                   unused_lsb_s;
  assign unused_lsb_s = ^{redirectAddr[1:0], updPc[1:0], updTarget[1:0]};

  assign lk_idx_s  = addr_r[IDXW+1:2];
  assign lk_tag_s  = addr_r[XLEN-1:IDXW+2];
  assign upd_idx_s = updPc[IDXW+1:2];
  assign upd_tag_s = updPc[XLEN-1:IDXW+2];

  // Combinational BTB lookup on the current fetch PC.
  always_comb begin
    lk_hit_s = valid_r[lk_idx_s]
               && (tag_r[lk_idx_s] == lk_tag_s)
               && (par_r[lk_idx_s] == entry_parity(tag_r[lk_idx_s], tgt_r[lk_idx_s]));
    // Counter values 2 and 3 both mean "taken".
    pred_s   = lk_hit_s && ctr_r[lk_idx_s][1];
  end

  // Tag check for the entry addressed by the resolved branch.
  always_comb begin
    upd_hit_s = valid_r[upd_idx_s]
                && (tag_r[upd_idx_s] == upd_tag_s)
                && (par_r[upd_idx_s] == entry_parity(tag_r[upd_idx_s], tgt_r[upd_idx_s]));
  end

  // Training decision: which fields of the selected entry change.
  always_comb begin
    entry_we_s = 1'b0;
    ctr_we_s   = 1'b0;
    ctr_nxt_s  = ctr_r[upd_idx_s];
    if (updValid) begin
      if (upd_hit_s) begin
        ctr_we_s = 1'b1;
        if (updTaken) begin
          entry_we_s = 1'b1;
          ctr_nxt_s  = ctr_inc(ctr_r[upd_idx_s]);
        end else begin
          ctr_nxt_s  = ctr_dec(ctr_r[upd_idx_s]);
        end
      end else if (updTaken) begin
        // Allocate, or evict an aliasing entry, as weakly taken.
        entry_we_s = 1'b1;
        ctr_we_s   = 1'b1;
        ctr_nxt_s  = 2'd2;
      end else begin
        // Not-taken miss: no allocation.
        entry_we_s = 1'b0;
      end
    end else begin
      entry_we_s = 1'b0;
    end
  end

  // Next-PC selection, highest priority first.
  always_comb begin
    pc_nxt_s = addr_r;
    if (resetIn) begin
      pc_nxt_s = RESET_VECTOR;
    end else if (redirect) begin
      // A flush beats a stall.
      pc_nxt_s = {redirectAddr[XLEN-1:2], 2'b00};
    end else if (locker == 1'b0) begin
      // An X/Z locker makes this condition unknown, so the advance path is
      // taken rather than the hold.
      pc_nxt_s = addr_r;
    end else if (pred_s) begin
      pc_nxt_s = {tgt_r[lk_idx_s], 2'b00};
    end else begin
      pc_nxt_s = addr_r + PC_STEP;
    end
  end

  // PC register and reset delay for IF_ID.
  always_ff @(posedge clk) begin
    addr_r      <= pc_nxt_s;
    reset_dly_r <= resetIn;
  end

  // Valid bits and counters; reset discards a same-cycle update.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      valid_r <= {BTB_ENTRIES{1'b0}};
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_r[i] <= 2'd0;
      end
    end else begin
      if (entry_we_s) begin
        valid_r[upd_idx_s] <= 1'b1;
      end
      if (ctr_we_s) begin
        ctr_r[upd_idx_s] <= ctr_nxt_s;
      end
    end
  end

  // Tag, target and parity payload; no reset needed because valid gates it.
  always_ff @(posedge clk) begin
    if (entry_we_s && !resetIn) begin
      tag_r[upd_idx_s] <= upd_tag_s;
      tgt_r[upd_idx_s] <= updTarget[XLEN-1:2];
      par_r[upd_idx_s] <= entry_parity(upd_tag_s, updTarget[XLEN-1:2]);
    end
  end

  assign addrOut   = addr_r;
  assign predTaken = pred_s;
  assign resetOut  = reset_dly_r;

endmodule

// File: tb/tb_pc_btb.sv
// -----------------------------------------------------------------------------
// tb_pc_btb: directed scenarios plus randomized traffic for pc_btb. A
// reference model tracks the PC and a table of BTB entries using plain
// address arithmetic.
// -----------------------------------------------------------------------------
module tb_pc_btb;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;
  localparam int          N    = 8;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        locker = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirectAddr = 32'h0;
  logic        updValid = 1'b0;
  logic [31:0] updPc = 32'h0;
  logic [31:0] updTarget = 32'h0;
  logic        updTaken = 1'b0;
  logic [31:0] addrOut;
  logic        predTaken;
  logic        resetOut;

  pc_btb #(.XLEN(XLEN), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
    .clk(clk), .resetIn(resetIn), .locker(locker), .redirect(redirect),
    .redirectAddr(redirectAddr), .updValid(updValid), .updPc(updPc),
    .updTarget(updTarget), .updTaken(updTaken), .addrOut(addrOut),
    .predTaken(predTaken), .resetOut(resetOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_rst_out;

  function automatic bit m_pred();
    int idx;
    idx = int'((m_pc / 4) % N);
    return m_valid[idx] && (m_tag[idx] == m_pc / (4 * N)) && (m_ctr[idx] >= 2);
  endfunction

  // One clock: drive inputs, step the model with the rules, sample at +1.
  task automatic cycle(input bit rst, input bit lk, input bit rd, input logic [31:0] ra,
                       input bit uv, input logic [31:0] upc, input logic [31:0] ut,
                       input bit utk);
    bit pred;
    int ui;
    logic [31:0] utag;
    resetIn = rst; locker = lk; redirect = rd; redirectAddr = ra;
    updValid = uv; updPc = upc; updTarget = ut; updTaken = utk;
    pred = m_pred();
    @(posedge clk);
    m_rst_out = rst;
    if (rst) begin
      m_pc = RV;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i] = 0;
      end
    end else begin
      if (rd) m_pc = ra & 32'hFFFF_FFFC;
      else if (!lk) m_pc = m_pc;
      else if (pred) m_pc = m_tgt[(m_pc / 4) % N];
      else m_pc = m_pc + 32'd4;
      if (uv) begin
        ui = int'((upc / 4) % N);
        utag = upc / (4 * N);
        if (m_valid[ui] && m_tag[ui] == utag) begin
          if (utk) begin
            m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            m_tgt[ui] = ut & 32'hFFFF_FFFC;
          end else begin
            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
          end
        end else if (utk) begin
          m_valid[ui] = 1'b1;
          m_tag[ui] = utag;
          m_tgt[ui] = ut & 32'hFFFF_FFFC;
          m_ctr[ui] = 2;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (addrOut !== 32'h100) $display("FAIL reset_addr: got %h want %h", addrOut, 32'h100); else passes++;
    checks++; if (predTaken !== 1'b0) $display("FAIL reset_pred: got %b want 0", predTaken); else passes++;
    do_reset();
    checks++; if (resetOut !== 1'b1) $display("FAIL reset_out: got %b want 1", resetOut); else passes++;
    checks++; if (addrOut !== 32'h100) $display("FAIL reset_hold: got %h want %h", addrOut, 32'h100); else passes++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      idle();
      exp = 32'h100 + 32'(4 * i);
      checks++; if (addrOut !== exp) $display("FAIL seq_addr%0d: got %h want %h", i, addrOut, exp); else passes++;
      checks++; if (resetOut !== 1'b0) $display("FAIL seq_rstout%0d: got %b want 0", i, resetOut); else passes++;
    end
  endtask

  task automatic test_stall_redirect();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (addrOut !== 32'h10C) $display("FAIL stall_hold%0d: got %h want %h", i, addrOut, 32'h10C); else passes++;
    end
    cycle(1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (addrOut !== 32'h200) $display("FAIL stall_redirect: got %h want %h", addrOut, 32'h200); else passes++;
    idle();
    checks++; if (addrOut !== 32'h204) $display("FAIL after_redirect: got %h want %h", addrOut, 32'h204); else passes++;
  endtask

  task automatic test_train_predict();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 32'h40, 1'b1);
    checks++; if (addrOut !== 32'h104) $display("FAIL train_addr: got %h want %h", addrOut, 32'h104); else passes++;
    idle();
    checks++; if (addrOut !== 32'h108) $display("FAIL train_at108: got %h want %h", addrOut, 32'h108); else passes++;
    checks++; if (predTaken !== 1'b1) $display("FAIL train_pred: got %b want 1", predTaken); else passes++;
    idle();
    checks++; if (addrOut !== 32'h40) $display("FAIL train_target: got %h want %h", addrOut, 32'h40); else passes++;
  endtask

  task automatic test_hysteresis();
    // Redirect and a taken update in the same cycle; counter saturates at 3.
    cycle(1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 32'h40, 1'b1);
    checks++; if (addrOut !== 32'h108) $display("FAIL hyst_redirect: got %h want %h", addrOut, 32'h108); else passes++;
    checks++; if (predTaken !== 1'b1) $display("FAIL hyst_ctr3: got %b want 1", predTaken); else passes++;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 32'h0, 1'b0);
    checks++; if (predTaken !== 1'b1) $display("FAIL hyst_ctr2: got %b want 1", predTaken); else passes++;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 32'h0, 1'b0);
    checks++; if (predTaken !== 1'b0) $display("FAIL hyst_ctr1: got %b want 0", predTaken); else passes++;
    idle();
    checks++; if (addrOut !== 32'h10C) $display("FAIL hyst_fallthru: got %h want %h", addrOut, 32'h10C); else passes++;
  endtask

  task automatic test_alias();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 32'h40, 1'b0);
    idle();
    checks++; if (predTaken !== 1'b0) $display("FAIL noalloc_pred: got %b want 0", predTaken); else passes++;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108, 32'h40, 1'b1);
    checks++; if (predTaken !== 1'b1) $display("FAIL alias_alloc: got %b want 1", predTaken); else passes++;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h108 + 32'(4 * N), 32'h80, 1'b1);
    checks++; if (predTaken !== 1'b0) $display("FAIL alias_evict: got %b want 0", predTaken); else passes++;
    cycle(1'b0, 1'b1, 1'b1, 32'h108 + 32'(4 * N), 1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (predTaken !== 1'b1) $display("FAIL alias_newhit: got %b want 1", predTaken); else passes++;
    idle();
    checks++; if (addrOut !== 32'h80) $display("FAIL alias_target: got %h want %h", addrOut, 32'h80); else passes++;
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++; if (addrOut !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want %h", addrOut, 32'hFFFF_FFFC); else passes++;
    idle();
    checks++; if (addrOut !== 32'h0) $display("FAIL wrap_zero: got %h want %h", addrOut, 32'h0); else passes++;
  endtask

  task automatic test_reset_discard();
    // Reset together with a redirect and a taken update for 0x100.
    cycle(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h100, 32'h40, 1'b1);
    checks++; if (addrOut !== 32'h100) $display("FAIL rstdisc_addr: got %h want %h", addrOut, 32'h100); else passes++;
    checks++; if (predTaken !== 1'b0) $display("FAIL rstdisc_pred: got %b want 0", predTaken); else passes++;
  endtask

  task automatic test_random();
    bit rst, lk, rd, uv, utk;
    logic [31:0] ra, upc, ut;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      lk  = ($urandom_range(0, 4) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      ra  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 3))
                                         : 32'h100 + 32'($urandom_range(0, 127));
      uv  = ($urandom_range(0, 9) < 4);
      upc = 32'h100 + 32'(4 * $urandom_range(0, 31));
      ut  = 32'h100 + 32'($urandom_range(0, 127));
      utk = ($urandom_range(0, 2) != 0);
      cycle(rst, lk, rd, ra, uv, upc, ut, utk);
      checks++; if (addrOut !== m_pc) $display("FAIL rand_addr@%0d: got %h want %h", n, addrOut, m_pc); else passes++;
      checks++; if (predTaken !== m_pred()) $display("FAIL rand_pred@%0d: got %b want %b", n, predTaken, m_pred()); else passes++;
      checks++; if (resetOut !== m_rst_out) $display("FAIL rand_rstout@%0d: got %b want %b", n, resetOut, m_rst_out); else passes++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_train_predict();
    test_hysteresis();
    test_alias();
    test_wrap();
    test_reset_discard();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
